fixed_point_div: RTL and testbench

FIXED_POINT_DIV -- requirements
Module: fixed_point_div

---
 rtl/fixed_point_div.sv | 131 +++++++++++++
 tb/tb_fixed_point_div.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fixed_point_div.sv
// fixed_point_div: sign-magnitude fixed-point divider, one restoring step per clock.
// Latency: result at edge k+N+1 after start at edge k (N = BITSIZE-1+FRAC); k+1 for a zero divisor.
// Backpressure: none; start is honoured only while idle (busy=0), requests made while busy are dropped.
//
// Ports:
//   clk, rst     - rising-edge clock, asynchronous active-high reset
//   start, A, B  - request, dividend and divisor (sign-magnitude, FRAC fractional bits)
//   Q            - registered quotient (sign-magnitude), held until the next result
//   valid        - one-cycle pulse marking a new Q
//   busy         - high whenever the FSM is not idle
//   div_by_zero  - Q is the saturated result of a zero-magnitude divisor
//   overflow     - Q is saturated because the quotient does not fit the magnitude field
module fixed_point_div #(
  parameter int BITSIZE = 16,
  parameter int FRAC    = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic [BITSIZE-1:0] A,
  input  logic [BITSIZE-1:0] B,
  output logic [BITSIZE-1:0] Q,
  output logic               valid,
  output logic               busy,
  output logic               div_by_zero,
  output logic               overflow
);

  localparam int MW = BITSIZE - 1;        // magnitude width
  localparam int N  = MW + FRAC;          // numerator width = number of division steps
  localparam int CW = $clog2(N + 1);

  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

  state_t        r_state;
  logic [N-1:0]  r_num;     // shifted dividend magnitude, consumed MSB first
  logic [N-1:0]  r_quo;     // raw quotient, built LSB first
  logic [MW-1:0] r_den;     // divisor magnitude
  logic [MW-1:0] r_rem;     // partial remainder, always < r_den
  logic          r_sign;
  logic [CW-1:0] r_cnt;

  logic [MW:0]   w_trial;
  logic          w_ge;
  logic [MW-1:0] w_diff;
  logic [MW-1:0] w_rem_next;
  logic          w_dz;
  logic          w_ovf;
  logic [MW-1:0] w_mag;

  // Restoring step: bring down the next numerator bit and subtract if it fits.
  assign w_trial    = {r_rem, r_num[N-1]};
  assign w_ge       = (w_trial >= {1'b0, r_den});
  // When w_ge holds the true difference is below r_den, so the low MW bits of the
  // modular subtraction are the whole answer.
  assign w_diff     = w_trial[MW-1:0] - r_den;
  assign w_rem_next = w_ge ? w_diff : w_trial[MW-1:0];

  assign w_dz  = (r_den == '0);
  assign w_ovf = |r_quo[N-1:MW];
  assign w_mag = r_quo[MW-1:0];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_num       <= '0;
      r_quo       <= '0;
      r_den       <= '0;
      r_rem       <= '0;
      r_sign      <= 1'b0;
      r_cnt       <= '0;
      Q           <= '0;
      valid       <= 1'b0;
      busy        <= 1'b0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      valid <= 1'b0;
      case (r_state)
        IDLE: begin
          if (start) begin
            r_num   <= {A[MW-1:0], {FRAC{1'b0}}};
            r_den   <= B[MW-1:0];
            r_sign  <= A[MW] ^ B[MW];
            r_rem   <= '0;
            r_quo   <= '0;
            r_cnt   <= '0;
            r_state <= CALC;
            busy    <= 1'b1;
          end
        end
        CALC: begin
          if (w_dz) begin
            // Zero divisor skips the iteration so its result lands one edge after start.
            Q           <= {r_sign, {MW{1'b1}}};
            div_by_zero <= 1'b1;
            overflow    <= 1'b0;
            valid       <= 1'b1;
            r_state     <= DONE;
          end else if (r_cnt == CW'(N)) begin
            if (w_ovf) begin
              Q        <= {r_sign, {MW{1'b1}}};
              overflow <= 1'b1;
            end else begin
              // A zero magnitude never carries a negative sign.
              Q        <= {r_sign & (|w_mag), w_mag};
              overflow <= 1'b0;
            end
            div_by_zero <= 1'b0;
            valid       <= 1'b1;
            r_state     <= DONE;
          end else begin
            r_rem <= w_rem_next;
            r_num <= {r_num[N-2:0], 1'b0};
            r_quo <= {r_quo[N-2:0], w_ge};
            r_cnt <= r_cnt + 1'b1;
          end
        end
        DONE: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
        default: begin
          r_state <= IDLE;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fixed_point_div.sv
// tb_fixed_point_div: scoreboard bench for fixed_point_div (BITSIZE=16, FRAC=8).
// Expected results come from an integer-division model pushed at request time.
// Each scenario task does its own comparisons; results are popped when valid pulses.
module tb_fixed_point_div;
  localparam int BITSIZE = 16;
  localparam int FRAC    = 8;
  localparam int N       = BITSIZE - 1 + FRAC;

  logic        clk = 1'b0;
  logic        rst;
  logic        start;
  logic [15:0] A;
  logic [15:0] B;
  logic [15:0] Q;
  logic        valid;
  logic        busy;
  logic        div_by_zero;
  logic        overflow;

  typedef struct packed {
    logic [15:0] q;
    logic        dz;
    logic        ov;
  } exp_t;

  exp_t sb[$];
  int   n_checks = 0;
  int   n_fail   = 0;

  fixed_point_div #(.BITSIZE(BITSIZE), .FRAC(FRAC)) dut (
    .clk(clk), .rst(rst), .start(start), .A(A), .B(B),
    .Q(Q), .valid(valid), .busy(busy),
    .div_by_zero(div_by_zero), .overflow(overflow)
  );

  always #5 clk = ~clk;

  function automatic exp_t model(input logic [15:0] a, input logic [15:0] b);
    exp_t e;
    longint unsigned ma, mb, raw;
    logic s;
    ma = 64'(a[14:0]);
    mb = 64'(b[14:0]);
    s  = a[15] ^ b[15];
    e  = '0;
    if (mb == 0) begin
      e.q  = {s, 15'h7fff};
      e.dz = 1'b1;
    end else begin
      raw = (ma << FRAC) / mb;
      if (raw > 64'h7fff) begin
        e.q  = {s, 15'h7fff};
        e.ov = 1'b1;
      end else begin
        e.q[14:0] = raw[14:0];
        e.q[15]   = (raw == 0) ? 1'b0 : s;
      end
    end
    return e;
  endfunction

  // Drive a one-cycle start; returns at the negedge after the sampling edge k.
  task automatic issue(input logic [15:0] a, input logic [15:0] b, input bit accepted);
    @(negedge clk);
    A = a;
    B = b;
    start = 1'b1;
    if (accepted) sb.push_back(model(a, b));
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
  endtask

  // Count edges after k until valid is observed (bounded).
  task automatic wait_valid(output int cyc, output bit seen);
    seen = 1'b0;
    cyc  = 0;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (valid) seen = 1'b1;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; A = '0; B = '0;
    #12;
    n_checks++; if (Q !== 16'h0000) begin n_fail++; $display("FAIL reset_q: got %h want 0000", Q); end
    n_checks++; if (valid !== 1'b0) begin n_fail++; $display("FAIL reset_valid: got %b want 0", valid); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
    n_checks++; if (div_by_zero !== 1'b0) begin n_fail++; $display("FAIL reset_dz: got %b want 0", div_by_zero); end
    n_checks++; if (overflow !== 1'b0) begin n_fail++; $display("FAIL reset_ov: got %b want 0", overflow); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    int   cyc;
    bit   seen, busy_ok;
    exp_t e;
    issue(16'h0300, 16'h0200, 1'b1);
    busy_ok = busy;
    cyc = 0; seen = 1'b0;
    while (!seen && cyc < 100) begin
      @(posedge clk);
      cyc++;
      @(negedge clk);
      if (!busy) busy_ok = 1'b0;
      if (valid) seen = 1'b1;
    end
    n_checks++; if (!seen || cyc != N + 1) begin n_fail++; $display("FAIL basic_latency: got %0d (seen=%0d) want %0d", cyc, seen, N + 1); end
    n_checks++; if (!busy_ok) begin n_fail++; $display("FAIL basic_busy_window: busy dropped before result, want high edges k..k+%0d", N + 1); end
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL basic_result: scoreboard empty"); end
    else begin
      e = sb.pop_front();
      if ({Q, div_by_zero, overflow} !== e)
        begin n_fail++; $display("FAIL basic_result: got Q=%h dz=%b ov=%b want Q=%h dz=%b ov=%b", Q, div_by_zero, overflow, e.q, e.dz, e.ov); end
    end
    n_checks++; if (Q !== 16'h0180) begin n_fail++; $display("FAIL basic_q_const: got %h want 0180", Q); end
    @(negedge clk);
    n_checks++; if (busy !== 1'b0 || valid !== 1'b0) begin n_fail++; $display("FAIL basic_after_done: got busy=%b valid=%b want 0 0", busy, valid); end
  endtask

  task automatic test_patterns();
    logic [15:0] ta [4] = '{16'h8300, 16'h0100, 16'h7F00, 16'h8000};
    logic [15:0] tb [4] = '{16'h0200, 16'h0300, 16'h0040, 16'h0200};
    logic [15:0] tq [4] = '{16'h8180, 16'h0055, 16'h7FFF, 16'h0000};
    logic [15:0] ra, rb;
    int   cyc;
    bit   seen;
    exp_t e;
    for (int i = 0; i < 8; i++) begin
      if (i < 4) begin ra = ta[i]; rb = tb[i]; end
      else begin
        ra = 16'($urandom_range(0, 16'hffff));
        rb = 16'($urandom_range(1, 16'hffff));
      end
      issue(ra, rb, 1'b1);
      wait_valid(cyc, seen);
      n_checks++;
      if (!seen || sb.size() == 0) begin n_fail++; $display("FAIL pattern_%0d: no result for A=%h B=%h", i, ra, rb); end
      else begin
        e = sb.pop_front();
        if ({Q, div_by_zero, overflow} !== e)
          begin n_fail++; $display("FAIL pattern_%0d: A=%h B=%h got Q=%h dz=%b ov=%b want Q=%h dz=%b ov=%b", i, ra, rb, Q, div_by_zero, overflow, e.q, e.dz, e.ov); end
      end
      if (i < 4) begin
        n_checks++;
        if (Q !== tq[i] || overflow !== (i == 2))
          begin n_fail++; $display("FAIL pattern_const_%0d: got Q=%h ov=%b want Q=%h ov=%b", i, Q, overflow, tq[i], (i == 2)); end
      end
    end
  endtask

  task automatic test_div_zero();
    int   cyc;
    bit   seen;
    exp_t e;
    issue(16'h0100, 16'h8000, 1'b1);
    wait_valid(cyc, seen);
    n_checks++; if (!seen || cyc != 1) begin n_fail++; $display("FAIL dz_latency: got %0d (seen=%0d) want 1", cyc, seen); end
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL dz_result: scoreboard empty"); end
    else begin
      e = sb.pop_front();
      if ({Q, div_by_zero, overflow} !== e)
        begin n_fail++; $display("FAIL dz_result: got Q=%h dz=%b ov=%b want Q=%h dz=%b ov=%b", Q, div_by_zero, overflow, e.q, e.dz, e.ov); end
    end
    n_checks++; if (Q !== 16'hFFFF || div_by_zero !== 1'b1 || overflow !== 1'b0)
      begin n_fail++; $display("FAIL dz_const: got Q=%h dz=%b ov=%b want FFFF 1 0", Q, div_by_zero, overflow); end
    repeat (3) @(negedge clk);
    n_checks++; if (valid !== 1'b0 || Q !== 16'hFFFF || div_by_zero !== 1'b1)
      begin n_fail++; $display("FAIL dz_hold: got valid=%b Q=%h dz=%b want 0 FFFF 1", valid, Q, div_by_zero); end
  endtask

  task automatic test_mid_calc_start();
    int   cyc;
    bit   seen, extra;
    exp_t e;
    issue(16'h0300, 16'h0200, 1'b1);
    repeat (4) @(negedge clk);
    issue(16'h0100, 16'h0300, 1'b0);
    wait_valid(cyc, seen);
    n_checks++;
    if (!seen || sb.size() == 0) begin n_fail++; $display("FAIL midcalc_result: no result"); end
    else begin
      e = sb.pop_front();
      if ({Q, div_by_zero, overflow} !== e)
        begin n_fail++; $display("FAIL midcalc_result: got Q=%h dz=%b ov=%b want Q=%h dz=%b ov=%b", Q, div_by_zero, overflow, e.q, e.dz, e.ov); end
    end
    extra = 1'b0;
    repeat (40) begin @(negedge clk); if (valid) extra = 1'b1; end
    n_checks++; if (extra || busy !== 1'b0) begin n_fail++; $display("FAIL midcalc_dropped: got extra_valid=%b busy=%b want 0 0", extra, busy); end
  endtask

  task automatic test_reset_abort();
    int   cyc;
    bit   seen, extra;
    exp_t e;
    issue(16'h0300, 16'h0200, 1'b1);
    repeat (10) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    sb.delete();
    n_checks++; if (Q !== 16'h0 || valid !== 1'b0 || busy !== 1'b0 || div_by_zero !== 1'b0 || overflow !== 1'b0)
      begin n_fail++; $display("FAIL abort_outputs: got Q=%h valid=%b busy=%b dz=%b ov=%b want all 0", Q, valid, busy, div_by_zero, overflow); end
    @(negedge clk);
    rst = 1'b0;
    extra = 1'b0;
    repeat (30) begin @(negedge clk); if (valid || busy) extra = 1'b1; end
    n_checks++; if (extra) begin n_fail++; $display("FAIL abort_no_valid: got activity after abort, want none"); end
    issue(16'h0100, 16'h0300, 1'b1);
    wait_valid(cyc, seen);
    n_checks++; if (!seen || cyc != N + 1) begin n_fail++; $display("FAIL abort_next_latency: got %0d (seen=%0d) want %0d", cyc, seen, N + 1); end
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL abort_next_result: scoreboard empty"); end
    else begin
      e = sb.pop_front();
      if ({Q, div_by_zero, overflow} !== e)
        begin n_fail++; $display("FAIL abort_next_result: got Q=%h dz=%b ov=%b want Q=%h dz=%b ov=%b", Q, div_by_zero, overflow, e.q, e.dz, e.ov); end
    end
  endtask

  task automatic test_back_to_back();
    int   cyc;
    bit   seen;
    exp_t e;
    issue(16'h0300, 16'h0200, 1'b1);
    wait_valid(cyc, seen);
    if (seen && sb.size() != 0) e = sb.pop_front();
    n_checks++; if (!seen || {Q, div_by_zero, overflow} !== e)
      begin n_fail++; $display("FAIL b2b_first: got Q=%h seen=%0d want Q=%h", Q, seen, e.q); end
    // The next issue drives start in the first idle cycle after DONE.
    issue(16'h8300, 16'h0200, 1'b1);
    wait_valid(cyc, seen);
    n_checks++; if (!seen || cyc != N + 1) begin n_fail++; $display("FAIL b2b_latency: got %0d (seen=%0d) want %0d", cyc, seen, N + 1); end
    n_checks++;
    if (sb.size() == 0) begin n_fail++; $display("FAIL b2b_second: scoreboard empty"); end
    else begin
      e = sb.pop_front();
      if ({Q, div_by_zero, overflow} !== e)
        begin n_fail++; $display("FAIL b2b_second: got Q=%h dz=%b ov=%b want Q=%h dz=%b ov=%b", Q, div_by_zero, overflow, e.q, e.dz, e.ov); end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_patterns();
    test_div_zero();
    test_mid_calc_start();
    test_reset_abort();
    test_back_to_back();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
